pwm_tone_rx: RTL and testbench

Receive-side counterpart of the PWM tone generator. Takes the differential pulse pair (`pwm_pos`, `pwm_neg`) produced by the dual PWM DACs and recovers one signed sample per PWM frame by measuring the high time on each line. Optionally it also measures the period of the recovered waveform in frames, which serves as a pitch estimate. Used as a loopback checker and as the front end of a pitch detector on the same 10 MHz clock domain.

---
 rtl/pwm_tone_rx.sv | 205 ++++++++++++++++++++
 tb/tb_pwm_tone_rx.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/pwm_tone_rx.sv
// pwm_tone_rx: recovers one signed sample per PWM frame from the pos/neg pulse pair.
// Define PWM_TONE_RX_PITCH_EN to compile in the zero-crossing period (pitch) measurement.
module pwm_tone_rx #(
  parameter int WIDTH     = 9,
  parameter int FRAME_LEN = 512,
  parameter int HYST      = 8,
  parameter int PERIOD_W  = 12
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pwm_pos,
  input  logic                  pwm_neg,
  output logic signed [WIDTH:0] sample,
  output logic                  sample_valid,
  output logic                  locked,
  output logic [PERIOD_W-1:0]   period,
  output logic                  period_valid
);

  localparam int               FCW        = (FRAME_LEN > 2) ? $clog2(FRAME_LEN) : 1;
  localparam logic [FCW-1:0]   LAST_POS   = FCW'(FRAME_LEN - 1);
  localparam logic [WIDTH-1:0] CNT_MAX    = '1;
  localparam logic [1:0]       MISS_LIMIT = 2'd3;

  if (FRAME_LEN < 2 || HYST < 0 || HYST > (1 << WIDTH) || PERIOD_W < 2) begin : g_bad_params
    $error("pwm_tone_rx: parameter out of range");
  end

  typedef enum logic {SEEK, LOCKED} state_t;

  state_t state;
  state_t state_next;

  logic pos_meta, pos_sync, pos_prev;
  logic neg_meta, neg_sync, neg_prev;
  logic pos_rise, neg_rise, any_rise;

  logic [FCW-1:0]   frame_cnt;
  logic [WIDTH-1:0] pos_cnt, neg_cnt;
  logic [WIDTH-1:0] pos_cnt_inc, neg_cnt_inc;
  logic [1:0]       miss_cnt;
  logic             mis_seen, aligned_seen;
  logic             frame_mis, frame_aligned;
  logic             frame_end, force_seek;
  logic signed [WIDTH:0] frame_diff;

  always_ff @(posedge clk) begin
    if (reset) begin
      pos_meta <= 1'b0;
      pos_sync <= 1'b0;
      pos_prev <= 1'b0;
      neg_meta <= 1'b0;
      neg_sync <= 1'b0;
      neg_prev <= 1'b0;
    end else begin
      pos_meta <= pwm_pos;
      pos_sync <= pos_meta;
      pos_prev <= pos_sync;
      neg_meta <= pwm_neg;
      neg_sync <= neg_meta;
      neg_prev <= neg_sync;
    end
  end

  assign pos_rise = pos_sync & ~pos_prev;
  assign neg_rise = neg_sync & ~neg_prev;
  assign any_rise = pos_rise | neg_rise;

  // The current cycle's level is folded in so the frame-end cycle is counted too.
  always_comb begin
    pos_cnt_inc = pos_cnt;
    neg_cnt_inc = neg_cnt;
    if (pos_sync && pos_cnt != CNT_MAX) pos_cnt_inc = pos_cnt + WIDTH'(1);
    if (neg_sync && neg_cnt != CNT_MAX) neg_cnt_inc = neg_cnt + WIDTH'(1);
  end

  assign frame_diff    = $signed({1'b0, pos_cnt_inc}) - $signed({1'b0, neg_cnt_inc});
  assign frame_end     = (state == LOCKED) && (frame_cnt == LAST_POS);
  assign frame_mis     = mis_seen | (any_rise & (frame_cnt != '0));
  assign frame_aligned = aligned_seen | (any_rise & (frame_cnt == '0));
  assign force_seek    = frame_end & frame_mis & ~frame_aligned & (miss_cnt == MISS_LIMIT);

  always_ff @(posedge clk) begin
    if (reset) state <= SEEK;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      SEEK:    if (any_rise)   state_next = LOCKED;
      LOCKED:  if (force_seek) state_next = SEEK;
      default: state_next = SEEK;
    endcase
  end

  always_comb begin
    locked = (state == LOCKED);
  end

  // The locking edge itself sits at frame position 0, so the first frame counts as aligned.
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_cnt    <= '0;
      pos_cnt      <= '0;
      neg_cnt      <= '0;
      miss_cnt     <= '0;
      mis_seen     <= 1'b0;
      aligned_seen <= 1'b0;
      sample       <= '0;
      sample_valid <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      case (state)
        SEEK: begin
          miss_cnt <= '0;
          mis_seen <= 1'b0;
          if (any_rise) begin
            frame_cnt    <= FCW'(1);
            pos_cnt      <= WIDTH'(pos_sync);
            neg_cnt      <= WIDTH'(neg_sync);
            aligned_seen <= 1'b1;
          end else begin
            frame_cnt    <= '0;
            pos_cnt      <= '0;
            neg_cnt      <= '0;
            aligned_seen <= 1'b0;
          end
        end
        LOCKED: begin
          if (frame_end) begin
            frame_cnt    <= '0;
            pos_cnt      <= '0;
            neg_cnt      <= '0;
            mis_seen     <= 1'b0;
            aligned_seen <= 1'b0;
            if (force_seek) begin
              miss_cnt <= '0;
            end else begin
              sample       <= frame_diff;
              sample_valid <= 1'b1;
              miss_cnt     <= (frame_mis && !frame_aligned) ? miss_cnt + 2'd1 : 2'd0;
            end
          end else begin
            frame_cnt    <= frame_cnt + FCW'(1);
            pos_cnt      <= pos_cnt_inc;
            neg_cnt      <= neg_cnt_inc;
            mis_seen     <= frame_mis;
            aligned_seen <= frame_aligned;
          end
        end
        default: begin
          frame_cnt <= '0;
          pos_cnt   <= '0;
          neg_cnt   <= '0;
        end
      endcase
    end
  end

`ifdef PWM_TONE_RX_PITCH_EN
  localparam logic signed [WIDTH:0]   NEG_HYST = (WIDTH+1)'(-HYST);
  localparam logic [PERIOD_W-1:0]     FCNT_MAX = '1;

  logic                armed, seen_cross, crossing, below_hyst;
  logic [PERIOD_W-1:0] frames_since;

  assign below_hyst = (sample <= NEG_HYST);
  assign crossing   = sample_valid & armed & ~sample[WIDTH];

  // Losing frame alignment makes the running count meaningless, so it is dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      armed        <= 1'b0;
      seen_cross   <= 1'b0;
      frames_since <= '0;
      period       <= '0;
      period_valid <= 1'b0;
    end else if (state != LOCKED) begin
      armed        <= 1'b0;
      seen_cross   <= 1'b0;
      frames_since <= '0;
      period_valid <= 1'b0;
    end else begin
      period_valid <= 1'b0;
      if (crossing) begin
        armed        <= 1'b0;
        seen_cross   <= 1'b1;
        frames_since <= PERIOD_W'(1);
        if (seen_cross) begin
          period       <= frames_since;
          period_valid <= 1'b1;
        end
      end else if (sample_valid) begin
        if (below_hyst) armed <= 1'b1;
        if (frames_since != FCNT_MAX) frames_since <= frames_since + PERIOD_W'(1);
      end
    end
  end
`else
  assign period       = '0;
  assign period_valid = 1'b0;
`endif

endmodule

// File: tb/tb_pwm_tone_rx.sv
// Directed self-checking bench for pwm_tone_rx: lock, sample values, lock loss, pitch, reset.
module tb_pwm_tone_rx;

  localparam int WIDTH     = 9;
  localparam int FRAME_LEN = 512;
  localparam int HYST      = 8;
  localparam int PERIOD_W  = 12;

  logic clk     = 1'b0;
  logic reset   = 1'b1;
  logic pwm_pos = 1'b0;
  logic pwm_neg = 1'b0;
  logic signed [WIDTH:0] sample;
  logic                  sample_valid;
  logic                  locked;
  logic [PERIOD_W-1:0]   period;
  logic                  period_valid;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int frame_start = 0;
  int exp_q[$];
  int pv_vals[$];
  int lock_rise_cyc = -1;
  int lock_fall_cyc = -1;
  int first_sv_cyc  = -1;
  int prev_sv_cyc   = -1;
  int pulse_err = 0;
  int pv_orphan = 0;
  logic locked_d = 1'b0;
  logic sv_d     = 1'b0;

  pwm_tone_rx #(
    .WIDTH(WIDTH),
    .FRAME_LEN(FRAME_LEN),
    .HYST(HYST),
    .PERIOD_W(PERIOD_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .pwm_pos(pwm_pos),
    .pwm_neg(pwm_neg),
    .sample(sample),
    .sample_valid(sample_valid),
    .locked(locked),
    .period(period),
    .period_valid(period_valid)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic checkOutput(input string tag, input int actual, input int expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  // One PWM frame (or a partial one when len < FRAME_LEN) starting at bench position 0.
  task automatic applyStimulus(input int pos_duty, input int neg_duty, input int len,
                               input bit want, input int want_val);
    if (want) exp_q.push_back(want_val);
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      if (i == 0) frame_start = cyc;
      pwm_pos = (i < pos_duty);
      pwm_neg = (i < neg_duty);
    end
  endtask

  always @(negedge clk) begin
    if (locked && !locked_d) lock_rise_cyc = cyc;
    if (!locked && locked_d) lock_fall_cyc = cyc;
    if (!locked) prev_sv_cyc = -1;
    if (sample_valid) begin
      if (sv_d) pulse_err++;
      if (exp_q.size() == 0) checkOutput("unexpected_sample", int'(sample), 9999);
      else checkOutput("sample", int'(sample), exp_q.pop_front());
      if (prev_sv_cyc >= 0) checkOutput("sample_spacing", cyc - prev_sv_cyc, FRAME_LEN);
      else first_sv_cyc = cyc;
      prev_sv_cyc = cyc;
    end
    if (period_valid) begin
      if (!sv_d) pv_orphan++;
      pv_vals.push_back(int'(period));
    end
    locked_d = locked;
    sv_d     = sample_valid;
  end

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int nz;
    int fs;
    int t_shift;
    nz = 0;

    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (sample !== '0 || sample_valid !== 1'b0 || locked !== 1'b0 ||
          period !== '0 || period_valid !== 1'b0) nz++;
      pwm_pos = ~pwm_pos;
      pwm_neg = (i % 3 == 0);
    end
    checkOutput("reset_nonzero_cycles", nz, 0);
    checkOutput("reset_sample", int'(sample), 0);
    checkOutput("reset_locked", int'(locked), 0);
    checkOutput("reset_period", int'(period), 0);
    @(negedge clk);
    reset = 1'b0;
    pwm_pos = 1'b0;
    pwm_neg = 1'b0;
    repeat (6) @(negedge clk);
    checkOutput("idle_locked", int'(locked), 0);

    applyStimulus(100, 0, FRAME_LEN, 1, 100);
    fs = frame_start;
    checkOutput("lock_latency", lock_rise_cyc - fs, 3);
    applyStimulus(100, 0, FRAME_LEN, 1, 100);
    checkOutput("first_sample_latency", first_sv_cyc - fs, 514);
    applyStimulus(100, 0, FRAME_LEN, 1, 100);
    applyStimulus(100, 0, FRAME_LEN, 1, 100);

    for (int i = 0; i < 3; i++) applyStimulus(0, 300, FRAME_LEN, 1, -300);
    for (int i = 0; i < 3; i++) applyStimulus(512, 0, FRAME_LEN, 1, 511);

    // 37-cycle phase shift: three misaligned frames still report, the fourth drops lock.
    applyStimulus(0, 0, 37, 0, 0);
    applyStimulus(100, 0, FRAME_LEN, 1, 100);
    t_shift = frame_start;
    applyStimulus(100, 0, FRAME_LEN, 1, 100);
    applyStimulus(100, 0, FRAME_LEN, 1, 100);
    applyStimulus(100, 0, FRAME_LEN, 0, 0);
    applyStimulus(100, 0, FRAME_LEN, 1, 100);
    fs = frame_start;
    applyStimulus(100, 0, FRAME_LEN, 1, 100);
    checkOutput("lock_loss_time", lock_fall_cyc - t_shift, 2013);
    checkOutput("relock_latency", lock_rise_cyc - fs, 3);
    checkOutput("relock_first_sample", first_sv_cyc - fs, 514);
    checkOutput("relocked", int'(locked), 1);

    pv_vals.delete();
    for (int blk = 0; blk < 5; blk++)
      for (int f = 0; f < 10; f++)
        if (blk[0]) applyStimulus(200, 0, FRAME_LEN, 1, 200);
        else        applyStimulus(0, 200, FRAME_LEN, 1, -200);
    applyStimulus(200, 0, FRAME_LEN, 1, 200);

    for (int i = 0; i < 4; i++) begin
      applyStimulus(5, 0, FRAME_LEN, 1, 5);
      applyStimulus(0, 5, FRAME_LEN, 1, -5);
    end
`ifdef PWM_TONE_RX_PITCH_EN
    checkOutput("period_hold", int'(period), 20);
    checkOutput("period_count", pv_vals.size(), 2);
    foreach (pv_vals[i]) checkOutput("period_value", pv_vals[i], 20);
`else
    checkOutput("period_tied", int'(period), 0);
    checkOutput("period_count", pv_vals.size(), 0);
`endif

    applyStimulus(100, 0, 200, 0, 0);
    @(negedge clk);
    reset = 1'b1;
    pwm_pos = 1'b1;
    @(negedge clk);
    checkOutput("midreset_sample", int'(sample), 0);
    checkOutput("midreset_sample_valid", int'(sample_valid), 0);
    checkOutput("midreset_locked", int'(locked), 0);
    checkOutput("midreset_period", int'(period), 0);
    checkOutput("midreset_period_valid", int'(period_valid), 0);
    repeat (3) begin
      @(negedge clk);
      pwm_pos = ~pwm_pos;
      pwm_neg = ~pwm_neg;
    end
    @(negedge clk);
    reset = 1'b0;
    pwm_pos = 1'b0;
    pwm_neg = 1'b0;
    repeat (20) @(negedge clk);
    checkOutput("post_reset_seek", int'(locked), 0);

    applyStimulus(50, 0, FRAME_LEN, 1, 50);
    fs = frame_start;
    applyStimulus(50, 0, FRAME_LEN, 1, 50);
    checkOutput("post_reset_lock_latency", lock_rise_cyc - fs, 3);
    checkOutput("post_reset_first_sample", first_sv_cyc - fs, 514);
    pwm_pos = 1'b0;
    repeat (5) @(negedge clk);

    checkOutput("samples_outstanding", exp_q.size(), 0);
    checkOutput("valid_pulse_width", pulse_err, 0);
    checkOutput("period_valid_timing", pv_orphan, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
